// File: rtl/video_timing_pkg.sv
// Shared timing definitions for the raster generator: the mode record,
// two stock modes and the helper that sums one axis into its total.
package video_timing_pkg;

   typedef struct packed {
      int h_active;
      int h_front;
      int h_sync;
      int h_back;
      int v_active;
      int v_front;
      int v_sync;
      int v_back;
   } timing_t;

   // 1280x720 at 60 Hz (74.25 MHz pixel clock)
   localparam timing_t MODE_720P60 = '{
      h_active: 1280, h_front: 110, h_sync: 40, h_back: 220,
      v_active: 720,  v_front: 5,   v_sync: 5,  v_back: 20
   };

   // 640x480 at 60 Hz (25.175 MHz pixel clock)
   localparam timing_t MODE_640X480 = '{
      h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
      v_active: 480, v_front: 10, v_sync: 2,  v_back: 33
   };

   function automatic int total(input int active, input int front,
                                input int sync, input int back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a wrapping position counter plus the combinational
// active / sync / boundary decode of the current count.
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int ACTIVE = 1,
   parameter int FRONT  = 1,
   parameter int SYNC   = 1,
   parameter int BACK   = 1,
   parameter int WIDTH  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap,
   output logic             first,
   output logic             active,
   output logic             sync,
   output logic             blank_start
);

   localparam int TOTAL = total(ACTIVE, FRONT, SYNC, BACK);

   // Refuse to build with a zero-length region or a total the counter cannot hold
   if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1 || WIDTH < 1 || WIDTH > 30 ||
       TOTAL > (2 ** WIDTH)) begin : g_bad_params
      $error("timing_axis: illegal timing parameters");
   end

   localparam logic [WIDTH-1:0] LAST     = WIDTH'(TOTAL - 1);
   localparam logic [WIDTH-1:0] ACT_END  = WIDTH'(ACTIVE);
   localparam logic [WIDTH-1:0] SYNC_BEG = WIDTH'(ACTIVE + FRONT);
   localparam logic [WIDTH-1:0] SYNC_END = WIDTH'(ACTIVE + FRONT + SYNC);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: step when told to, folding back to zero after the last position
   always_comb begin
      cnt_d = cnt_q;
      if (advance) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Position register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt         = cnt_q;
   assign wrap        = advance && (cnt_q == LAST);
   assign first       = (cnt_q == '0);
   assign active      = (cnt_q < ACT_END);
   assign sync        = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);
   assign blank_start = (cnt_q == ACT_END);

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: two chained axis counters with a registered
// output stage (one cycle of decode latency) and a vblank interrupt.
// Build option: define VIDEO_TIMING_VBLANK_IRQ_EN for a latched,
// acknowledged interrupt; otherwise int_vblank is a plain vblank level.
module video_timing
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE   = MODE_720P60.h_active,
   parameter int H_FRONT    = MODE_720P60.h_front,
   parameter int H_SYNC     = MODE_720P60.h_sync,
   parameter int H_BACK     = MODE_720P60.h_back,
   parameter int V_ACTIVE   = MODE_720P60.v_active,
   parameter int V_FRONT    = MODE_720P60.v_front,
   parameter int V_SYNC     = MODE_720P60.v_sync,
   parameter int V_BACK     = MODE_720P60.v_back,
   parameter bit H_SYNC_POL = 1'b1,
   parameter bit V_SYNC_POL = 1'b1,
   parameter int X_WIDTH    = 12,
   parameter int Y_WIDTH    = 11
) (
   input  logic               pixel_clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               int_ack,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [X_WIDTH-1:0] x,
   output logic [Y_WIDTH-1:0] y,
   output logic               line_start,
   output logic               frame_start,
   output logic               int_vblank
);

   logic [X_WIDTH-1:0] h_cnt;
   logic [Y_WIDTH-1:0] v_cnt;
   logic h_wrap, h_first, h_active, h_sync, h_blank_start;
   logic v_wrap, v_first, v_active, v_sync, v_blank_start;

   timing_axis #(
      .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .WIDTH(X_WIDTH)
   ) u_h_axis (
      .clk(pixel_clk), .reset(reset), .advance(enable),
      .cnt(h_cnt), .wrap(h_wrap), .first(h_first), .active(h_active),
      .sync(h_sync), .blank_start(h_blank_start)
   );

   timing_axis #(
      .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .WIDTH(Y_WIDTH)
   ) u_v_axis (
      .clk(pixel_clk), .reset(reset), .advance(h_wrap),
      .cnt(v_cnt), .wrap(v_wrap), .first(v_first), .active(v_active),
      .sync(v_sync), .blank_start(v_blank_start)
   );

   logic unused_axis;
   assign unused_axis = v_wrap ^ h_blank_start;

   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               de_q, de_d;
   logic [X_WIDTH-1:0] x_q, x_d;
   logic [Y_WIDTH-1:0] y_q, y_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic               int_vblank_q, int_vblank_d;
   logic               vblank_set;

   assign vblank_set = enable && h_first && v_blank_start;

   // Output decode: follow the counters while running; when stopped, hold
   // sync levels and position but suppress video and strobes
   always_comb begin
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      x_d           = x_q;
      y_d           = y_q;
      de_d          = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (enable) begin
         hsync_d       = h_sync ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_d       = v_sync ? V_SYNC_POL : ~V_SYNC_POL;
         x_d           = h_cnt;
         y_d           = v_cnt;
         de_d          = h_active && v_active;
         line_start_d  = h_first;
         frame_start_d = h_first && v_first;
      end
   end

`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
   // Latched interrupt: vblank entry sets it, ack clears it, set beats ack
   always_comb begin
      int_vblank_d = int_vblank_q;
      if (int_ack) begin
         int_vblank_d = 1'b0;
      end
      if (vblank_set) begin
         int_vblank_d = 1'b1;
      end
   end
`else
   logic unused_irq;
   assign unused_irq = int_ack ^ vblank_set;

   // Level interrupt: mirrors vertical blanking of the decoded line
   always_comb begin
      int_vblank_d = int_vblank_q;
      if (enable) begin
         int_vblank_d = ~v_active;
      end
   end
`endif

   // Registered outputs
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         hsync_q       <= ~H_SYNC_POL;
         vsync_q       <= ~V_SYNC_POL;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         int_vblank_q  <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         int_vblank_q  <= int_vblank_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign int_vblank  = int_vblank_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing in a small 8x6 mode with a position-based reference model.
module tb_video_timing;

   localparam int HA = 4, HF = 1, HS = 1, HB = 2;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic       pixel_clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       int_ack = 1'b0;
   logic       hsync, vsync, de, line_start, frame_start, int_vblank;
   logic [3:0] x;
   logic [2:0] y;

   int checks = 0;
   int errors = 0;

   // reference model: raster position plus the expected registered outputs
   int   m_h = 0, m_v = 0;
   int   e_x = 0, e_y = 0;
   logic e_de = 0, e_ls = 0, e_fs = 0, e_hs = 0, e_vs = 0, e_irq = 0;

   video_timing #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .X_WIDTH(4), .Y_WIDTH(3)
   ) dut (
      .pixel_clk(pixel_clk), .reset(reset), .enable(enable), .int_ack(int_ack),
      .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start), .int_vblank(int_vblank)
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic step(input logic r, input logic en, input logic ack);
      reset = r;
      enable = en;
      int_ack = ack;
      @(posedge pixel_clk);
      if (r) begin
         m_h = 0; m_v = 0; e_x = 0; e_y = 0;
         e_de = 0; e_ls = 0; e_fs = 0; e_hs = 0; e_vs = 0; e_irq = 0;
      end else if (en) begin
         e_x  = m_h;
         e_y  = m_v;
         e_de = (m_h < HA) && (m_v < VA);
         e_hs = (m_h >= HA + HF) && (m_h < HA + HF + HS);
         e_vs = (m_v >= VA + VF) && (m_v < VA + VF + VS);
         e_ls = (m_h == 0);
         e_fs = (m_h == 0) && (m_v == 0);
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
         e_irq = ((m_h == 0) && (m_v == VA)) || (e_irq && !ack);
`else
         e_irq = (m_v >= VA);
`endif
         m_h = m_h + 1;
         if (m_h == HT) begin
            m_h = 0;
            m_v = (m_v + 1) % VT;
         end
      end else begin
         e_de = 0; e_ls = 0; e_fs = 0;
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
         e_irq = e_irq && !ack;
`endif
      end
      #1;
   endtask

   task automatic wait_pos(input int tx, input int ty);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(0, 1, 0);
         if (x == 4'(tx) && y == 3'(ty)) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_pos timeout: got x=%0d y=%0d, wanted x=%0d y=%0d", x, y, tx, ty);
      end
   endtask

   task automatic test_reset;
      step(1, 0, 0);
      step(1, 1, 0);
      checks++;
      if ({hsync, vsync, de, line_start, frame_start, int_vblank, x, y} !== 13'd0) begin
         errors++;
         $display("FAIL reset_state: hs=%b vs=%b de=%b ls=%b fs=%b irq=%b x=%0d y=%0d, want all 0",
                  hsync, vsync, de, line_start, frame_start, int_vblank, x, y);
      end
      step(0, 1, 0);
      checks++;
      if ({de, frame_start, line_start, x, y} !== {3'b111, 4'd0, 3'd0}) begin
         errors++;
         $display("FAIL first_edge: de=%b fs=%b ls=%b x=%0d y=%0d, want de=1 fs=1 ls=1 x=0 y=0",
                  de, frame_start, line_start, x, y);
      end
   endtask

   task automatic test_frame;
      int cycles = 0;
      int de_cnt = 1;
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         step(0, 1, 0);
         cycles++;
         if (frame_start) done = 1;
         else if (de) de_cnt++;
      end
      checks++;
      if (cycles !== HT * VT) begin
         errors++;
         $display("FAIL frame_period: got %0d cycles, want %0d", cycles, HT * VT);
      end
      checks++;
      if (de_cnt !== HA * VA) begin
         errors++;
         $display("FAIL de_per_frame: got %0d, want %0d", de_cnt, HA * VA);
      end
   endtask

   task automatic test_sync;
      int hs_cnt = 0;
      int vs_cnt = 0;
      for (int i = 0; i < HT * VT; i++) begin
         if (i != 0) step(0, 1, 0);
         hs_cnt += int'(hsync);
         vs_cnt += int'(vsync);
         checks++;
         if (hsync !== (x == 4'd5) || vsync !== (y == 3'd4)) begin
            errors++;
            $display("FAIL sync_decode: x=%0d y=%0d hs=%b vs=%b, want hs=%b vs=%b",
                     x, y, hsync, vsync, x == 4'd5, y == 3'd4);
         end
      end
      checks++;
      if (hs_cnt !== VT || vs_cnt !== HT) begin
         errors++;
         $display("FAIL sync_counts: hs=%0d vs=%0d, want hs=%0d vs=%0d", hs_cnt, vs_cnt, VT, HT);
      end
   endtask

   task automatic test_irq;
      logic prev;
      wait_pos(0, 1);
      step(0, 1, 1);
      wait_pos(7, 2);
      prev = int_vblank;
      step(0, 1, 0);
      checks++;
      if ({prev, int_vblank, x, y} !== {2'b01, 4'd0, 3'd3}) begin
         errors++;
         $display("FAIL irq_rise: before=%b after=%b at x=%0d y=%0d, want 0 then 1 at (0,3)",
                  prev, int_vblank, x, y);
      end
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
      wait_pos(0, 0);
      checks++;
      if (int_vblank !== 1'b1) begin
         errors++;
         $display("FAIL irq_hold_wrap: got %b, want 1", int_vblank);
      end
      step(0, 1, 1);
      checks++;
      if (int_vblank !== 1'b0) begin
         errors++;
         $display("FAIL irq_ack: got %b, want 0", int_vblank);
      end
`else
      wait_pos(0, 0);
      checks++;
      if (int_vblank !== 1'b0) begin
         errors++;
         $display("FAIL irq_level_clear: got %b, want 0", int_vblank);
      end
`endif
   endtask

   task automatic test_ack_collision;
      wait_pos(0, 1);
      step(0, 1, 1);
      wait_pos(7, 2);
      checks++;
      if (int_vblank !== 1'b0) begin
         errors++;
         $display("FAIL collision_pre: got %b, want 0", int_vblank);
      end
      step(0, 1, 1);
      checks++;
      if (int_vblank !== 1'b1) begin
         errors++;
         $display("FAIL collision_set_wins: got %b, want 1", int_vblank);
      end
   endtask

   task automatic test_enable_hold;
      wait_pos(2, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0);
         checks++;
         if ({x, y, de, line_start, frame_start} !== {4'd2, 3'd1, 3'b000}) begin
            errors++;
            $display("FAIL enable_hold: x=%0d y=%0d de=%b ls=%b fs=%b, want x=2 y=1 de=0 ls=0 fs=0",
                     x, y, de, line_start, frame_start);
         end
      end
      step(0, 1, 0);
      checks++;
      if ({x, y, de} !== {4'd3, 3'd1, 1'b1}) begin
         errors++;
         $display("FAIL enable_resume: x=%0d y=%0d de=%b, want x=3 y=1 de=1", x, y, de);
      end
   endtask

   task automatic test_reset_midframe;
      wait_pos(6, 4);
      step(1, 1, 0);
      checks++;
      if ({hsync, vsync, de, x, y, int_vblank, line_start, frame_start} !== 13'd0) begin
         errors++;
         $display("FAIL reset_midframe: hs=%b vs=%b de=%b x=%0d y=%0d irq=%b ls=%b fs=%b, want all 0",
                  hsync, vsync, de, x, y, int_vblank, line_start, frame_start);
      end
      step(0, 1, 0);
      checks++;
      if ({de, frame_start, x, y} !== {2'b11, 4'd0, 3'd0}) begin
         errors++;
         $display("FAIL reset_restart: de=%b fs=%b x=%0d y=%0d, want de=1 fs=1 x=0 y=0",
                  de, frame_start, x, y);
      end
   endtask

   task automatic test_random;
      logic r, en, ack;
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 79) == 0);
         en  = ($urandom_range(0, 3) != 0);
         ack = ($urandom_range(0, 9) == 0);
         step(r, en, ack);
         checks++;
         if ({hsync, vsync, de, line_start, frame_start, int_vblank, x, y} !==
             {e_hs, e_vs, e_de, e_ls, e_fs, e_irq, 4'(e_x), 3'(e_y)}) begin
            errors++;
            $display("FAIL random[%0d]: got hs=%b vs=%b de=%b ls=%b fs=%b irq=%b x=%0d y=%0d, want hs=%b vs=%b de=%b ls=%b fs=%b irq=%b x=%0d y=%0d",
                     i, hsync, vsync, de, line_start, frame_start, int_vblank, x, y,
                     e_hs, e_vs, e_de, e_ls, e_fs, e_irq, e_x, e_y);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_sync();
      test_irq();
      test_ack_collision();
      test_enable_hold();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
